readreg_stage: RTL and testbench

- Pipeline stage between rename and issue in the out-of-order core.
- Drives the physical register file's readreg read ports with source IDs of renamed instructions.
- Captures the returned operand data and valid flags into a one-deep pipeline register, and presents the result to issue.
- Supports issue backpressure and commit flush.

---
 rtl/readreg_stage_if.sv | 56 +++++
 rtl/readreg_stage.sv | 116 +++++++++++
 tb/tb_readreg_stage.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/readreg_stage_if.sv
// Interface bundling the rename, regfile, writeback, issue and flush signals
// around the readreg stage. The stage is the slave; its environment is the master.
interface readreg_stage_if #(
    parameter int READREG_WIDTH    = 4,
    parameter int PHY_REG_ID_WIDTH = 6,
    parameter int REG_DATA_WIDTH   = 32,
    parameter int WB_WIDTH         = 4,
    parameter int PAYLOAD_WIDTH    = 64
);
    // rename side
    logic [READREG_WIDTH-1:0]                             rename_readreg_valid;
    logic [READREG_WIDTH-1:0][1:0][PHY_REG_ID_WIDTH-1:0]  rename_readreg_rs_id;
    logic [READREG_WIDTH-1:0][1:0]                        rename_readreg_rs_need;
    logic [READREG_WIDTH-1:0][PAYLOAD_WIDTH-1:0]          rename_readreg_payload;
    logic                                                 readreg_rename_stall;
    // physical register file read ports
    logic [READREG_WIDTH-1:0][1:0][PHY_REG_ID_WIDTH-1:0]  readreg_phyf_id;
    logic [READREG_WIDTH-1:0][1:0][REG_DATA_WIDTH-1:0]    phyf_readreg_data;
    logic [READREG_WIDTH-1:0][1:0]                        phyf_readreg_data_valid;
    // writeback snoop ports
    logic [WB_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]            wb_phyf_id;
    logic [WB_WIDTH-1:0][REG_DATA_WIDTH-1:0]              wb_phyf_data;
    logic [WB_WIDTH-1:0]                                  wb_phyf_we;
    // issue side and commit flush
    logic                                                 issue_readreg_stall;
    logic                                                 commit_readreg_flush;
    logic [READREG_WIDTH-1:0]                             readreg_issue_valid;
    logic [READREG_WIDTH-1:0][1:0][PHY_REG_ID_WIDTH-1:0]  readreg_issue_src_id;
    logic [READREG_WIDTH-1:0][1:0]                        readreg_issue_src_loaded;
    logic [READREG_WIDTH-1:0][1:0][REG_DATA_WIDTH-1:0]    readreg_issue_src_data;
    logic [READREG_WIDTH-1:0][PAYLOAD_WIDTH-1:0]          readreg_issue_payload;

    modport slave (
        input  rename_readreg_valid, rename_readreg_rs_id, rename_readreg_rs_need,
        input  rename_readreg_payload,
        output readreg_rename_stall,
        output readreg_phyf_id,
        input  phyf_readreg_data, phyf_readreg_data_valid,
        input  wb_phyf_id, wb_phyf_data, wb_phyf_we,
        input  issue_readreg_stall, commit_readreg_flush,
        output readreg_issue_valid, readreg_issue_src_id, readreg_issue_src_loaded,
        output readreg_issue_src_data, readreg_issue_payload
    );

    modport master (
        output rename_readreg_valid, rename_readreg_rs_id, rename_readreg_rs_need,
        output rename_readreg_payload,
        input  readreg_rename_stall,
        input  readreg_phyf_id,
        output phyf_readreg_data, phyf_readreg_data_valid,
        output wb_phyf_id, wb_phyf_data, wb_phyf_we,
        output issue_readreg_stall, commit_readreg_flush,
        input  readreg_issue_valid, readreg_issue_src_id, readreg_issue_src_loaded,
        input  readreg_issue_src_data, readreg_issue_payload
    );
endinterface

// File: rtl/readreg_stage.sv
// readreg_stage: rename -> issue pipeline stage. Drives regfile read IDs,
// captures operand data/ready flags into a one-deep register, handles issue
// stall and commit flush.
// Optional macro READREG_WB_SNOOP_EN: while stalled, unloaded operands of held
// entries pick up matching writeback data (lowest-index wb port wins).
module readreg_stage #(
    parameter int READREG_WIDTH    = 4,
    parameter int PHY_REG_ID_WIDTH = 6,
    parameter int REG_DATA_WIDTH   = 32,
    parameter int WB_WIDTH         = 4,
    parameter int PAYLOAD_WIDTH    = 64
) (
    input logic             clk,
    input logic             rst,
    readreg_stage_if.slave  bus
);
    localparam logic [PHY_REG_ID_WIDTH-1:0] NO_READ_ID = '1;

    logic [READREG_WIDTH-1:0]                            vld_p0;
    logic [READREG_WIDTH-1:0][1:0][PHY_REG_ID_WIDTH-1:0] id_p0;
    logic [READREG_WIDTH-1:0][1:0]                       loaded_p0;
    logic [READREG_WIDTH-1:0][1:0][REG_DATA_WIDTH-1:0]   data_p0;
    logic [READREG_WIDTH-1:0][PAYLOAD_WIDTH-1:0]         payload_p0;

    assign bus.readreg_rename_stall = bus.issue_readreg_stall;

    // Regfile read request: real ID only for used operands of valid slots.
    always_comb begin
        bus.readreg_phyf_id = '0;
        for (int i = 0; i < READREG_WIDTH; i++) begin
            for (int j = 0; j < 2; j++) begin
                bus.readreg_phyf_id[i][j] =
                    (bus.rename_readreg_valid[i] && bus.rename_readreg_rs_need[i][j])
                    ? bus.rename_readreg_rs_id[i][j] : NO_READ_ID;
            end
        end
    end

`ifdef READREG_WB_SNOOP_EN
    logic [READREG_WIDTH-1:0][1:0]                     snoop_hit;
    logic [READREG_WIDTH-1:0][1:0][REG_DATA_WIDTH-1:0] snoop_data;

    // Writeback match per held operand; descending scan lets port 0 win.
    always_comb begin
        snoop_hit  = '0;
        snoop_data = '0;
        for (int i = 0; i < READREG_WIDTH; i++) begin
            for (int j = 0; j < 2; j++) begin
                for (int k = WB_WIDTH - 1; k >= 0; k--) begin
                    if (bus.wb_phyf_we[k] && (bus.wb_phyf_id[k] == id_p0[i][j])) begin
                        snoop_hit[i][j]  = 1'b1;
                        snoop_data[i][j] = bus.wb_phyf_data[k];
                    end
                end
            end
        end
    end
`else
    // Held entries stay frozen; writeback ports are not consumed here.
    logic unused_wb;
    assign unused_wb = ^{bus.wb_phyf_id, bus.wb_phyf_data, bus.wb_phyf_we};
`endif

    // ---- stage p0: rename/regfile capture into the issue register ----
    // Reset, then flush, then capture, then hold (with optional snoop).
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p0     <= '0;
            id_p0      <= '0;
            loaded_p0  <= '0;
            data_p0    <= '0;
            payload_p0 <= '0;
        end else if (bus.commit_readreg_flush) begin
            vld_p0    <= '0;
            loaded_p0 <= '0;
            data_p0   <= '0;
        end else if (!bus.issue_readreg_stall) begin
            vld_p0     <= bus.rename_readreg_valid;
            id_p0      <= bus.rename_readreg_rs_id;
            payload_p0 <= bus.rename_readreg_payload;
            for (int i = 0; i < READREG_WIDTH; i++) begin
                for (int j = 0; j < 2; j++) begin
                    if (!bus.rename_readreg_valid[i]) begin
                        loaded_p0[i][j] <= 1'b0;
                        data_p0[i][j]   <= '0;
                    end else if (!bus.rename_readreg_rs_need[i][j]) begin
                        loaded_p0[i][j] <= 1'b1;
                        data_p0[i][j]   <= '0;
                    end else begin
                        loaded_p0[i][j] <= bus.phyf_readreg_data_valid[i][j];
                        data_p0[i][j]   <= bus.phyf_readreg_data_valid[i][j]
                                           ? bus.phyf_readreg_data[i][j] : '0;
                    end
                end
            end
        end
`ifdef READREG_WB_SNOOP_EN
        else begin
            for (int i = 0; i < READREG_WIDTH; i++) begin
                for (int j = 0; j < 2; j++) begin
                    if (vld_p0[i] && !loaded_p0[i][j] && snoop_hit[i][j]) begin
                        loaded_p0[i][j] <= 1'b1;
                        data_p0[i][j]   <= snoop_data[i][j];
                    end
                end
            end
        end
`endif
    end

    assign bus.readreg_issue_valid      = vld_p0;
    assign bus.readreg_issue_src_id     = id_p0;
    assign bus.readreg_issue_src_loaded = loaded_p0;
    assign bus.readreg_issue_src_data   = data_p0;
    assign bus.readreg_issue_payload    = payload_p0;
endmodule

// File: tb/tb_readreg_stage.sv
// Directed self-checking bench for readreg_stage (expects READREG_WB_SNOOP_EN
// to be defined or not consistently with the RTL build).
module tb_readreg_stage;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    readreg_stage_if bus ();

    readreg_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.rename_readreg_valid    = '0;
        bus.rename_readreg_rs_id    = '0;
        bus.rename_readreg_rs_need  = '0;
        bus.rename_readreg_payload  = '0;
        bus.phyf_readreg_data       = '0;
        bus.phyf_readreg_data_valid = '0;
        bus.wb_phyf_id              = '0;
        bus.wb_phyf_data            = '0;
        bus.wb_phyf_we              = '0;
        bus.issue_readreg_stall     = 1'b0;
        bus.commit_readreg_flush    = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        bus.rename_readreg_valid   = 4'hF;
        bus.rename_readreg_rs_need = 8'hFF;
        bus.phyf_readreg_data_valid = 8'hFF;
        bus.phyf_readreg_data[0][0] = 32'hFFFF_FFFF;
        tick();
        tick();
        check("rst_valid",  64'(bus.readreg_issue_valid), 64'h0);
        check("rst_loaded", 64'(bus.readreg_issue_src_loaded), 64'h0);
        check("rst_data",   64'(|bus.readreg_issue_src_data), 64'h0);
        check("rst_payload", 64'(|bus.readreg_issue_payload), 64'h0);
        bus.issue_readreg_stall = 1'b1;
        #1;
        check("rst_stall_follow", 64'(bus.readreg_rename_stall), 64'h1);
        bus.issue_readreg_stall = 1'b0;
        #1;
        check("stall_follow_lo", 64'(bus.readreg_rename_stall), 64'h0);

        // Capture: slot0 rs1=5 ready; slot1 rs1=7 ready, rs2=9 unused.
        clear_inputs();
        rst = 1'b1;
        bus.rename_readreg_valid        = 4'b0011;
        bus.rename_readreg_rs_id[0][0]  = 6'd5;
        bus.rename_readreg_rs_id[0][1]  = 6'd6;
        bus.rename_readreg_rs_need[0]   = 2'b01;
        bus.phyf_readreg_data[0][0]     = 32'hDEAD_BEEF;
        bus.phyf_readreg_data_valid[0]  = 2'b01;
        bus.rename_readreg_rs_id[1][0]  = 6'd7;
        bus.rename_readreg_rs_id[1][1]  = 6'd9;
        bus.rename_readreg_rs_need[1]   = 2'b01;
        bus.phyf_readreg_data[1][0]     = 32'h0000_0011;
        bus.phyf_readreg_data[1][1]     = 32'h0000_0099;
        bus.phyf_readreg_data_valid[1]  = 2'b11;
        bus.rename_readreg_rs_id[2][0]  = 6'd3;
        bus.rename_readreg_rs_need[2]   = 2'b11;
        bus.rename_readreg_payload[0]   = 64'hA5A5_0000_0000_0001;
        #1;
        check("rdid_s0r1", 64'(bus.readreg_phyf_id[0][0]), 64'd5);
        check("rdid_s0r2_unused", 64'(bus.readreg_phyf_id[0][1]), 64'h3F);
        check("rdid_s1r2_unused", 64'(bus.readreg_phyf_id[1][1]), 64'h3F);
        check("rdid_s2_invalid", 64'(bus.readreg_phyf_id[2][0]), 64'h3F);
        tick();
        check("cap_valid", 64'(bus.readreg_issue_valid), 64'h3);
        check("cap_s0_loaded", 64'(bus.readreg_issue_src_loaded[0][0]), 64'h1);
        check("cap_s0_data", 64'(bus.readreg_issue_src_data[0][0]), 64'hDEAD_BEEF);
        check("cap_s0_id", 64'(bus.readreg_issue_src_id[0][0]), 64'd5);
        check("cap_s0_payload", bus.readreg_issue_payload[0], 64'hA5A5_0000_0000_0001);
        check("cap_s1r2_loaded", 64'(bus.readreg_issue_src_loaded[1][1]), 64'h1);
        check("cap_s1r2_data", 64'(bus.readreg_issue_src_data[1][1]), 64'h0);
        check("cap_s1r2_id", 64'(bus.readreg_issue_src_id[1][1]), 64'd9);
        check("cap_s1r1_data", 64'(bus.readreg_issue_src_data[1][0]), 64'h11);
        check("cap_s2_loaded", 64'(bus.readreg_issue_src_loaded[2]), 64'h0);

        // Not-ready operand, partially valid bundle 0101; slot1 invalid but id 12.
        clear_inputs();
        bus.rename_readreg_valid        = 4'b0101;
        bus.rename_readreg_rs_id[0][0]  = 6'd1;
        bus.rename_readreg_rs_need[0]   = 2'b01;
        bus.phyf_readreg_data[0][0]     = 32'h0000_0AAA;
        bus.phyf_readreg_data_valid[0]  = 2'b01;
        bus.rename_readreg_rs_id[1][0]  = 6'd12;
        bus.rename_readreg_rs_need[1]   = 2'b01;
        bus.rename_readreg_rs_id[2][0]  = 6'd12;
        bus.rename_readreg_rs_need[2]   = 2'b01;
        bus.phyf_readreg_data[2][0]     = 32'h0000_0BAD;
        bus.phyf_readreg_data_valid[2]  = 2'b00;
        // A wb match on a capture cycle must be ignored.
        bus.wb_phyf_id[0]   = 6'd12;
        bus.wb_phyf_data[0] = 32'h0000_7777;
        bus.wb_phyf_we      = 4'b0001;
        tick();
        check("nr_valid", 64'(bus.readreg_issue_valid), 64'h5);
        check("nr_loaded", 64'(bus.readreg_issue_src_loaded[2][0]), 64'h0);
        check("nr_data", 64'(bus.readreg_issue_src_data[2][0]), 64'h0);
        check("nr_id", 64'(bus.readreg_issue_src_id[2][0]), 64'd12);
        check("nr_s0_data", 64'(bus.readreg_issue_src_data[0][0]), 64'hAAA);

        // Stall cycle 1 with snoop candidates: port0 we=0, port2 and port3 hit 12.
        clear_inputs();
        bus.issue_readreg_stall         = 1'b1;
        bus.rename_readreg_valid        = 4'hF;
        bus.rename_readreg_rs_id[0][0]  = 6'd40;
        bus.rename_readreg_rs_need      = 8'hFF;
        bus.phyf_readreg_data_valid     = 8'hFF;
        bus.phyf_readreg_data[0][0]     = 32'h0000_4040;
        bus.wb_phyf_id[0]   = 6'd12;
        bus.wb_phyf_data[0] = 32'h0000_9999;
        bus.wb_phyf_id[2]   = 6'd12;
        bus.wb_phyf_data[2] = 32'h0000_1234;
        bus.wb_phyf_id[3]   = 6'd12;
        bus.wb_phyf_data[3] = 32'h0000_5678;
        bus.wb_phyf_we      = 4'b1100;
        #1;
        check("stall_out", 64'(bus.readreg_rename_stall), 64'h1);
        tick();
        check("st1_valid", 64'(bus.readreg_issue_valid), 64'h5);
        check("st1_id", 64'(bus.readreg_issue_src_id[0][0]), 64'd1);
`ifdef READREG_WB_SNOOP_EN
        check("snoop_loaded", 64'(bus.readreg_issue_src_loaded[2][0]), 64'h1);
        check("snoop_data", 64'(bus.readreg_issue_src_data[2][0]), 64'h1234);
`else
        check("frozen_loaded", 64'(bus.readreg_issue_src_loaded[2][0]), 64'h0);
        check("frozen_data", 64'(bus.readreg_issue_src_data[2][0]), 64'h0);
`endif
        check("snoop_invalid_slot", 64'(bus.readreg_issue_src_loaded[1][0]), 64'h0);
        bus.wb_phyf_we = '0;
        bus.rename_readreg_rs_id[0][0] = 6'd41;
        tick();
        bus.rename_readreg_rs_id[0][0] = 6'd42;
        bus.phyf_readreg_data[0][0]    = 32'h0000_4242;
        tick();
        check("st3_valid", 64'(bus.readreg_issue_valid), 64'h5);
        check("st3_id", 64'(bus.readreg_issue_src_id[0][0]), 64'd1);
        check("st3_data", 64'(bus.readreg_issue_src_data[0][0]), 64'hAAA);
        check("st3_stall_out", 64'(bus.readreg_rename_stall), 64'h1);

        // Release captures the current inputs.
        bus.issue_readreg_stall = 1'b0;
        tick();
        check("rel_valid", 64'(bus.readreg_issue_valid), 64'hF);
        check("rel_id", 64'(bus.readreg_issue_src_id[0][0]), 64'd42);
        check("rel_data", 64'(bus.readreg_issue_src_data[0][0]), 64'h4242);
        check("rel_loaded", 64'(bus.readreg_issue_src_loaded), 64'hFF);

        // Flush beats stall.
        bus.issue_readreg_stall  = 1'b1;
        bus.commit_readreg_flush = 1'b1;
        tick();
        check("flush_valid", 64'(bus.readreg_issue_valid), 64'h0);
        check("flush_loaded", 64'(bus.readreg_issue_src_loaded), 64'h0);
        check("flush_data", 64'(|bus.readreg_issue_src_data), 64'h0);
        bus.commit_readreg_flush = 1'b0;
        bus.issue_readreg_stall  = 1'b0;
        tick();
        check("post_flush_valid", 64'(bus.readreg_issue_valid), 64'hF);

        // Reset while stalled drops contents; next capture is normal.
        bus.issue_readreg_stall = 1'b1;
        rst = 1'b0;
        tick();
        check("rst_stalled_valid", 64'(bus.readreg_issue_valid), 64'h0);
        check("rst_stalled_id", 64'(bus.readreg_issue_src_id[0][0]), 64'h0);
        rst = 1'b1;
        bus.issue_readreg_stall = 1'b0;
        bus.rename_readreg_valid = 4'b1000;
        bus.rename_readreg_rs_id[3][1] = 6'd33;
        bus.rename_readreg_rs_need[3]  = 2'b10;
        bus.phyf_readreg_data[3][1]    = 32'hCAFE_F00D;
        bus.phyf_readreg_data_valid[3] = 2'b10;
        tick();
        check("rst_recap_valid", 64'(bus.readreg_issue_valid), 64'h8);
        check("rst_recap_data", 64'(bus.readreg_issue_src_data[3][1]), 64'hCAFE_F00D);
        check("rst_recap_loaded", 64'(bus.readreg_issue_src_loaded[3]), 64'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
